alu_slice_sequencer: RTL and testbench

Multi-precision sequencer for the team's n-bit ALU. It accepts W = N*SLICES-bit operands and feeds them to the ALU one N-bit slice per cycle, least-significant slice first. The ALU's carry/borrow output is fed back into its carry/borrow input between slices, and the returned slices are assembled into a W-bit result. It sits both directly upstream of the ALU (driving A, B, CB_in and Mode) and directly downstream of it (consuming Result and CB_out).

---
 rtl/alu_slice_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_slice_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_slice_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_slice_sequencer
// Purpose  : Feeds W = N*SLICES-bit operands to an N-bit ALU, least-significant
//            slice first, chaining carry/borrow and assembling the W-bit result.
//            Optional zero flag output enabled by macro ALU_SEQ_ZFLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_slice_sequencer #(
  parameter int N      = 4,
  parameter int SLICES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N*SLICES-1:0] a_in,
  input  logic [N*SLICES-1:0] b_in,
  input  logic [2:0]          mode_in,
  input  logic                cin_in,
  output logic                busy,
  output logic                done,
  output logic [N*SLICES-1:0] result_out,
  output logic                cout_out,
`ifdef ALU_SEQ_ZFLAG_EN
  output logic                zero_out,
`endif
  output logic [N-1:0]        alu_a,
  output logic [N-1:0]        alu_b,
  output logic                alu_cb_in,
  output logic [2:0]          alu_mode,
  input  logic [N-1:0]        alu_result,
  input  logic                alu_cb_out
);

  localparam int W  = N * SLICES;
  localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;

  localparam logic [1:0]    c_idle = 2'd0;
  localparam logic [1:0]    c_run  = 2'd1;
  localparam logic [1:0]    c_done = 2'd2;
  localparam logic [CW-1:0] c_last = CW'(SLICES - 1);

  logic [1:0]    r_state;
  logic [W-1:0]  r_a_sh;
  logic [W-1:0]  r_b_sh;
  // Only the upper W-N bits of the assembled result need to be remembered;
  // the newest slice arrives combinationally from the ALU.
  logic [W-N-1:0] r_acc;
  logic [2:0]    r_mode;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_result;
  logic          r_cout;
  logic [W-1:0]  w_acc_next;
  logic          w_run;

`ifdef ALU_SEQ_ZFLAG_EN
  logic r_nonzero;
  logic r_zero;
`endif

  assign w_run      = (r_state == c_run);
  assign w_acc_next = {alu_result, r_acc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_idle;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_acc     <= '0;
      r_mode    <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_cout    <= 1'b0;
`ifdef ALU_SEQ_ZFLAG_EN
      r_nonzero <= 1'b0;
      r_zero    <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_idle: begin
          if (start) begin
            r_a_sh    <= a_in;
            r_b_sh    <= b_in;
            r_mode    <= mode_in;
            r_carry   <= cin_in;
            r_cnt     <= '0;
`ifdef ALU_SEQ_ZFLAG_EN
            r_nonzero <= 1'b0;
`endif
            r_state   <= c_run;
          end
        end
        c_run: begin
          r_acc     <= w_acc_next[W-1:N];
          r_carry   <= alu_cb_out;
          r_a_sh    <= r_a_sh >> N;
          r_b_sh    <= r_b_sh >> N;
          r_cnt     <= r_cnt + 1'b1;
`ifdef ALU_SEQ_ZFLAG_EN
          r_nonzero <= r_nonzero | (|alu_result);
`endif
          if (r_cnt == c_last) begin
            r_result <= w_acc_next;
            r_cout   <= alu_cb_out;
`ifdef ALU_SEQ_ZFLAG_EN
            r_zero   <= ~(r_nonzero | (|alu_result));
`endif
            r_state  <= c_done;
          end
        end
        c_done:  r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

  assign busy       = w_run;
  assign done       = (r_state == c_done);
  assign result_out = r_result;
  assign cout_out   = r_cout;
`ifdef ALU_SEQ_ZFLAG_EN
  assign zero_out   = r_zero;
`endif

  // ALU drive is forced quiet outside RUN.
  assign alu_a     = w_run ? r_a_sh[N-1:0] : '0;
  assign alu_b     = w_run ? r_b_sh[N-1:0] : '0;
  assign alu_cb_in = w_run ? r_carry : 1'b0;
  assign alu_mode  = w_run ? r_mode : 3'b000;

endmodule
`default_nettype wire

// File: tb/tb_alu_slice_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_slice_sequencer
// Purpose  : Directed self-checking bench for alu_slice_sequencer (N=4, SLICES=4)
//            with a behavioural adder standing in for the ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_slice_sequencer;

  localparam int N      = 4;
  localparam int SLICES = 4;
  localparam int W      = N * SLICES;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [2:0]   mode_in;
  logic         cin_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result_out;
  logic         cout_out;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic         alu_cb_in;
  logic [2:0]   alu_mode;
  logic [N-1:0] alu_result;
  logic         alu_cb_out;
  logic         zero_obs;
  logic [N:0]   w_sum;

  int n_tests = 0;
  int n_fail  = 0;

  alu_slice_sequencer #(.N(N), .SLICES(SLICES)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .mode_in    (mode_in),
    .cin_in     (cin_in),
    .busy       (busy),
    .done       (done),
    .result_out (result_out),
    .cout_out   (cout_out),
`ifdef ALU_SEQ_ZFLAG_EN
    .zero_out   (zero_obs),
`endif
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cb_in  (alu_cb_in),
    .alu_mode   (alu_mode),
    .alu_result (alu_result),
    .alu_cb_out (alu_cb_out)
  );

`ifndef ALU_SEQ_ZFLAG_EN
  assign zero_obs = 1'b0;
`endif

  // Mode 000 adder: A + B + CB_in; other modes pass A through.
  assign w_sum      = (alu_mode == 3'b000) ? ({1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cb_in})
                                           : {1'b0, alu_a};
  assign alu_result = w_sum[N-1:0];
  assign alu_cb_out = w_sum[N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and check slice-by-slice timing and the final result.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] exp_r, input logic exp_c,
                        input logic exp_z, input logic [SLICES-1:0] exp_cb);
    start = 1'b1; a_in = a; b_in = b; cin_in = cin; mode_in = 3'b000;
    tick();
    start = 1'b0;
    for (int i = 0; i < SLICES; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
      chk({tag, "_cb_in"}, {31'd0, alu_cb_in}, {31'd0, exp_cb[i]});
      chk({tag, "_alu_a"}, {28'd0, alu_a}, {28'd0, a[i*N +: N]});
      tick();
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_result"}, {16'd0, result_out}, {16'd0, exp_r});
    chk({tag, "_cout"}, {31'd0, cout_out}, {31'd0, exp_c});
`ifdef ALU_SEQ_ZFLAG_EN
    chk({tag, "_zero"}, {31'd0, zero_obs}, {31'd0, exp_z});
`else
    if (exp_z !== exp_z) n_fail++;
`endif
    tick();
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; mode_in = 3'b000; cin_in = 1'b0;
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", {16'd0, result_out}, 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_result", {16'd0, result_out}, 32'd0);
    chk("idle_alu_a", {28'd0, alu_a}, 32'd0);
    chk("idle_alu_b", {28'd0, alu_b}, 32'd0);
    chk("idle_cout", {31'd0, cout_out}, 32'd0);

    run_op("add_00ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 4'b0110);
    run_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b1110);

    // start held high; operands changed during RUN must not disturb the result
    start = 1'b1; a_in = 16'h1234; b_in = 16'h1111; cin_in = 1'b0;
    tick();
    a_in = 16'hFFFF; b_in = 16'hFFFF;
    chk("hold_busy0", {31'd0, busy}, 32'd1);
    repeat (SLICES) tick();
    chk("hold_done", {31'd0, done}, 32'd1);
    chk("hold_result", {16'd0, result_out}, 32'h2345);
    chk("hold_cout", {31'd0, cout_out}, 32'd0);
    tick();
    chk("hold_idle_after_done", {31'd0, busy}, 32'd0);
    chk("hold_done_clear", {31'd0, done}, 32'd0);
    tick();
    chk("hold_second_accept", {31'd0, busy}, 32'd1);
    start = 1'b0;
    repeat (SLICES) tick();
    chk("hold2_done", {31'd0, done}, 32'd1);
    chk("hold2_result", {16'd0, result_out}, 32'hFFFE);
    chk("hold2_cout", {31'd0, cout_out}, 32'd1);
    tick();

    // asynchronous abort during the third slice
    start = 1'b1; a_in = 16'h0FFF; b_in = 16'h0001; cin_in = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("abort_pre_alu_a", {28'd0, alu_a}, 32'hF);
    chk("abort_pre_cb", {31'd0, alu_cb_in}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", {16'd0, result_out}, 32'd0);
    chk("abort_cout", {31'd0, cout_out}, 32'd0);
    chk("abort_alu_a", {28'd0, alu_a}, 32'd0);
    chk("abort_cb", {31'd0, alu_cb_in}, 32'd0);
    chk("abort_zero", {31'd0, zero_obs}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < SLICES + 2; k++) begin
      tick();
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end

    run_op("add_0001", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
